pc_next_unit: RTL and testbench
===============================

// Module: pc_next_unit
// PURPOSE
// - Program-counter stage that consumes the word-aligned branch offset produced by the shift-left-2 stage.
// - Forms the branch target (pc_plus4 + offset), the jump target and the jr target, then selects the next PC.
// - Holds the PC register and drives the fetch address.
// - Buffers one redirect that arrives while the pipeline is stalled, so a taken branch is never lost.
// PARAMETERS
// - RESET_PC  32'h0000_0000  PC value loaded on reset.
// - ADDR_W    32             PC/address width; the jump logic requires 32.
// PORTS
// - clk            in   1       clock; single clock domain.
// - reset          in   1       synchronous, active-high reset.
// - stall          in   1       1 = hold PC this cycle.
// - branch         in   1       beq-class instruction at current pc.
// - zero           in   1       ALU zero flag; branch taken = branch & zero.
// - branch_offset  in   32      sign-extended offset, already shifted left by 2.
// - jump           in   1       j/jal at current pc.
// - jump_index     in   26      instr[25:0].
// - jr             in   1       jr at current pc.
// - jr_target      in   32      register-file rs value.
// - pc             out  32      current fetch address (registered).
// - pc_plus4       out  32      pc + 4, combinational.
// - redirect       out  1       registered; 1 for the cycle after pc loaded a non-sequential target (IF/ID flush).
// - misaligned     out  1       registered; pulses with redirect when the requested target[1:0] != 0.
// BEHAVIOUR
// - Reset (sync, active-high; overrides everything, incl. mid-HOLD):
//   - pc=RESET_PC, redirect=0, misaligned=0.
//   - pending target cleared; state=RUN.
// - Targets (all arithmetic mod 2^32, no overflow flag):
//   - br_tgt = pc_plus4 + branch_offset.
//   - j_tgt  = {pc_plus4[31:28], jump_index, 2'b00}.
//   - jr_tgt = jr_target.
// - Request priority: jr > jump > (branch & zero) > sequential. req = jr | jump | (branch & zero).
// - Any loaded target has bits [1:0] forced to 00; misaligned reports whether the original bits were nonzero.
// - FSM states RUN, HOLD:
//   - RUN, stall=0: pc <= req ? sel_tgt : pc_plus4.
//     - redirect <= req; misaligned <= req & |sel_tgt[1:0].
//   - RUN, stall=1, req=1: pending <= sel_tgt; go HOLD; pc holds; redirect <= 0.
//   - RUN, stall=1, req=0: pc holds; redirect <= 0.
//   - HOLD, stall=1: pc and pending hold; new requests ignored (younger, wrong-path).
//   - HOLD, stall=0: pc <= pending (inputs ignored this cycle).
//     - redirect <= 1; misaligned from pending; go RUN.
// - Latency: one cycle from request (unstalled) to pc update; redirect is high in that same following cycle.
// - Wrap: pc=32'hFFFF_FFFC, no request -> pc=32'h0000_0000, redirect=0.
// - Backward branch: negative offset wraps mod 2^32, same as any other target.
// STRUCTURE
// - Shared package mips_pc_pkg:
//   - typedef pc_state_t {RUN, HOLD}.
//   - localparam PC_INC = 32'd4.
//   - localparam RESET_PC_DEFAULT.
// - One combinational sub-module pc_target_calc:
//   - inputs: pc_plus4, branch_offset, jump_index, jr_target, request flags.
//   - outputs: sel_tgt, req.
// - The top level holds the pc register, the pending register, the FSM, and the redirect/misaligned flops.
// TESTING
// - Reset then 3 cycles, no request -> pc = 0, 4, 8, 0xC; redirect = 0.
// - Taken branch: pc=0x10, branch=1, zero=1, offset=0x20 -> next pc=0x34, redirect=1 for one cycle.
// - Not taken: branch=1, zero=0 -> pc+4.
// - Priority: pc=0x40, jr=1 (jr_target=0x100) with jump=1 and a taken branch -> pc=0x100.
//   - Then jump_index=0x000_0010 alone -> pc=0x40 (pc_plus4[31:28]=0).
// - Stall capture: stall=1 for 3 cycles while a taken branch to 0x200 is presented on the 1st cycle only.
//   - A jump to 0x300 on the 2nd cycle is ignored.
//   - Stall drops -> pc=0x200, redirect=1.
// - Reset mid-HOLD: assert reset in HOLD -> pc=RESET_PC, state=RUN, pending discarded (no later redirect).
// - Edges:
//   - pc=0xFFFF_FFFC sequential -> 0x0.
//   - jr_target=0x103 -> pc=0x100, misaligned=1 with redirect=1.

Source files
------------

// File: rtl/mips_pc_pkg.sv
// Shared types and constants for the PC stage: FSM encoding, increment and reset address.
package mips_pc_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } pc_state_t;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_target_calc.sv
// Branch/jump/jr target formation and priority select; purely combinational, no backpressure.
module pc_target_calc #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_pc_plus4,
    input  logic [ADDR_W-1:0] i_branch_offset,
    input  logic [25:0]       i_jump_index,
    input  logic [ADDR_W-1:0] i_jr_target,
    input  logic              i_branch,
    input  logic              i_zero,
    input  logic              i_jump,
    input  logic              i_jr,
    output logic [ADDR_W-1:0] o_sel_tgt,
    output logic              o_req
);

    logic [ADDR_W-1:0] w_br_tgt;
    logic [ADDR_W-1:0] w_j_tgt;
    logic              w_br_taken;

    assign w_br_taken = i_branch & i_zero;
    assign w_br_tgt   = i_pc_plus4 + i_branch_offset;
    // Jump stays inside the 256 MB region of the delay-slot address.
    assign w_j_tgt    = {i_pc_plus4[ADDR_W-1 -: 4], i_jump_index, 2'b00};
    assign o_req      = i_jr | i_jump | w_br_taken;

    always_comb begin
        o_sel_tgt = i_pc_plus4;
        if (i_jr) begin
            o_sel_tgt = i_jr_target;
        end else if (i_jump) begin
            o_sel_tgt = w_j_tgt;
        end else if (w_br_taken) begin
            o_sel_tgt = w_br_tgt;
        end
    end

endmodule

// File: rtl/pc_next_unit.sv
// PC register and next-PC select; one cycle from request to pc update, redirect flagged the same cycle.
// A redirect requested under stall is parked in a pending register and applied when the stall drops.
module pc_next_unit
    import mips_pc_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch,
    input  logic              zero,
    input  logic [ADDR_W-1:0] branch_offset,
    input  logic              jump,
    input  logic [25:0]       jump_index,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              redirect,
    output logic              misaligned
);

    pc_state_t         r_state;
    pc_state_t         w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] r_pending;
    logic [ADDR_W-1:0] w_pending_nxt;
    logic              r_redirect;
    logic              w_redirect_nxt;
    logic              r_misaligned;
    logic              w_misaligned_nxt;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_sel_tgt;
    logic              w_req;

    assign w_pc_plus4 = r_pc + PC_INC[ADDR_W-1:0];

    pc_target_calc #(
        .ADDR_W (ADDR_W)
    ) u_target_calc (
        .i_pc_plus4      (w_pc_plus4),
        .i_branch_offset (branch_offset),
        .i_jump_index    (jump_index),
        .i_jr_target     (jr_target),
        .i_branch        (branch),
        .i_zero          (zero),
        .i_jump          (jump),
        .i_jr            (jr),
        .o_sel_tgt       (w_sel_tgt),
        .o_req           (w_req)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_pending_nxt    = r_pending;
        w_redirect_nxt   = 1'b0;
        w_misaligned_nxt = 1'b0;
        unique case (r_state)
            RUN: begin
                if (!stall) begin
                    w_pc_nxt         = w_req ? {w_sel_tgt[ADDR_W-1:2], 2'b00} : w_pc_plus4;
                    w_redirect_nxt   = w_req;
                    w_misaligned_nxt = w_req & (|w_sel_tgt[1:0]);
                end else if (w_req) begin
                    w_pending_nxt = w_sel_tgt;
                    w_state_nxt   = HOLD;
                end
            end
            HOLD: begin
                // Requests seen while holding come from younger wrong-path instructions.
                if (!stall) begin
                    w_pc_nxt         = {r_pending[ADDR_W-1:2], 2'b00};
                    w_redirect_nxt   = 1'b1;
                    w_misaligned_nxt = |r_pending[1:0];
                    w_state_nxt      = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= RUN;
            r_pc         <= RESET_PC;
            r_pending    <= '0;
            r_redirect   <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_pending    <= w_pending_nxt;
            r_redirect   <= w_redirect_nxt;
            r_misaligned <= w_misaligned_nxt;
        end
    end

    assign pc         = r_pc;
    assign pc_plus4   = w_pc_plus4;
    assign redirect   = r_redirect;
    assign misaligned = r_misaligned;

endmodule

// File: tb/tb_pc_next_unit.sv
// Vector table plus scoreboard queue for pc_next_unit; hand sequences cover reset-in-HOLD and wrap.
module tb_pc_next_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch;
    logic        zero;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic        misaligned;

    always #5 clk = ~clk;

    pc_next_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch        (branch),
        .zero          (zero),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .jr            (jr),
        .jr_target     (jr_target),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .redirect      (redirect),
        .misaligned    (misaligned)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        st;
        logic        br;
        logic        z;
        logic [31:0] off;
        logic        j;
        logic [25:0] jidx;
        logic        r;
        logic [31:0] rtgt;
        logic [31:0] e_pc;
        logic        e_red;
        logic        e_mis;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        red;
        logic        mis;
    } exp_t;

    exp_t        sb[$];
    vec_t        tbl[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] model_pc;

    function automatic vec_t mk(string n, logic st, logic br, logic z, logic [31:0] off,
                                logic j, logic [25:0] jidx, logic r, logic [31:0] rtgt,
                                logic [31:0] e_pc, logic e_red, logic e_mis);
        vec_t v;
        v.name = n; v.rst = 1'b0; v.st = st; v.br = br; v.z = z; v.off = off;
        v.j = j; v.jidx = jidx; v.r = r; v.rtgt = rtgt;
        v.e_pc = e_pc; v.e_red = e_red; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        reset = v.rst; stall = v.st; branch = v.br; zero = v.z; branch_offset = v.off;
        jump = v.j; jump_index = v.jidx; jr = v.r; jr_target = v.rtgt;
        #1;
        check({v.name, ".pc_plus4"}, pc_plus4, model_pc + 32'd4);
        sb.push_back('{pc: v.e_pc, red: v.e_red, mis: v.e_mis});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({v.name, ".pc"}, pc, e.pc);
        check({v.name, ".redirect"}, {31'd0, redirect}, {31'd0, e.red});
        check({v.name, ".misaligned"}, {31'd0, misaligned}, {31'd0, e.mis});
        model_pc = e.pc;
    endtask

    initial begin
        vec_t v;
        reset = 1'b1; stall = 1'b0; branch = 1'b0; zero = 1'b0; branch_offset = '0;
        jump = 1'b0; jump_index = '0; jr = 1'b0; jr_target = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.pc", pc, 32'h0);
        check("reset.redirect", {31'd0, redirect}, 32'd0);
        check("reset.misaligned", {31'd0, misaligned}, 32'd0);
        model_pc = 32'h0;

        //          name        st br z  off            j  jidx        r  rtgt           e_pc           red mis
        tbl.push_back(mk("seq1",   0, 0, 0, 32'h0,        0, 26'h0,      0, 32'h0,        32'h4,         0, 0));
        tbl.push_back(mk("seq2",   0, 0, 0, 32'h0,        0, 26'h0,      0, 32'h0,        32'h8,         0, 0));
        tbl.push_back(mk("seq3",   0, 0, 0, 32'h0,        0, 26'h0,      0, 32'h0,        32'hC,         0, 0));
        tbl.push_back(mk("seq4",   0, 0, 0, 32'h0,        0, 26'h0,      0, 32'h0,        32'h10,        0, 0));
        tbl.push_back(mk("br_tk",  0, 1, 1, 32'h20,       0, 26'h0,      0, 32'h0,        32'h34,        1, 0));
        tbl.push_back(mk("br_nt",  0, 1, 0, 32'h20,       0, 26'h0,      0, 32'h0,        32'h38,        0, 0));
        tbl.push_back(mk("seq5",   0, 0, 0, 32'h0,        0, 26'h0,      0, 32'h0,        32'h3C,        0, 0));
        tbl.push_back(mk("seq6",   0, 0, 0, 32'h0,        0, 26'h0,      0, 32'h0,        32'h40,        0, 0));
        tbl.push_back(mk("prio",   0, 1, 1, 32'h8,        1, 26'h55,     1, 32'h100,      32'h100,       1, 0));
        tbl.push_back(mk("jump",   0, 0, 0, 32'h0,        1, 26'h10,     0, 32'h0,        32'h40,        1, 0));
        tbl.push_back(mk("stl_br", 1, 1, 1, 32'h1BC,      0, 26'h0,      0, 32'h0,        32'h40,        0, 0));
        tbl.push_back(mk("stl_j",  1, 0, 0, 32'h0,        1, 26'hC0,     0, 32'h0,        32'h40,        0, 0));
        tbl.push_back(mk("stl_3",  1, 0, 0, 32'h0,        0, 26'h0,      0, 32'h0,        32'h40,        0, 0));
        tbl.push_back(mk("unstl",  0, 0, 0, 32'h0,        1, 26'hC0,     0, 32'h0,        32'h200,       1, 0));
        tbl.push_back(mk("seq7",   0, 0, 0, 32'h0,        0, 26'h0,      0, 32'h0,        32'h204,       0, 0));
        tbl.push_back(mk("jr_mis", 0, 0, 0, 32'h0,        0, 26'h0,      1, 32'h103,      32'h100,       1, 1));
        tbl.push_back(mk("seq8",   0, 0, 0, 32'h0,        0, 26'h0,      0, 32'h0,        32'h104,       0, 0));
        tbl.push_back(mk("br_bk",  0, 1, 1, 32'hFFFF_FFF8, 0, 26'h0,     0, 32'h0,        32'h100,       1, 0));
        tbl.push_back(mk("stl_jr", 1, 0, 0, 32'h0,        0, 26'h0,      1, 32'h207,      32'h100,       0, 0));
        tbl.push_back(mk("hold_m", 0, 0, 0, 32'h0,        0, 26'h0,      0, 32'h0,        32'h204,       1, 1));
        tbl.push_back(mk("seq9",   0, 0, 0, 32'h0,        0, 26'h0,      0, 32'h0,        32'h208,       0, 0));

        foreach (tbl[i]) apply(tbl[i]);

        // Reset arriving while a redirect is parked must discard it.
        apply(mk("rh_cap", 1, 1, 1, 32'hF4, 0, 26'h0, 0, 32'h0, 32'h208, 0, 0));
        v = mk("rh_rst", 1, 0, 0, 32'h0, 0, 26'h0, 1, 32'h500, 32'h0, 0, 0);
        v.rst = 1'b1;
        apply(v);
        apply(mk("rh_run1", 0, 0, 0, 32'h0, 0, 26'h0, 0, 32'h0, 32'h4, 0, 0));
        apply(mk("rh_run2", 0, 0, 0, 32'h0, 0, 26'h0, 0, 32'h0, 32'h8, 0, 0));

        // Sequential wrap at the top of the address space.
        apply(mk("wr_jr",  0, 0, 0, 32'h0, 0, 26'h0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0));
        apply(mk("wrap",   0, 0, 0, 32'h0, 0, 26'h0, 0, 32'h0,         32'h0,         0, 0));

        // Jump keeps the upper nibble of pc_plus4.
        apply(mk("hi_jr",  0, 0, 0, 32'h0, 0, 26'h0, 1, 32'hF000_0000, 32'hF000_0000, 1, 0));
        apply(mk("hi_j",   0, 0, 0, 32'h0, 1, 26'h1, 0, 32'h0,         32'hF000_0004, 1, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
